led_pwm_fader: RTL and testbench

Downstream consumer of the TramelBlaze-loaded 16-bit LED register. Converts each static LED bit into a PWM-dimmed board LED drive with a global brightness (duty) register. Bits that turn off decay linearly over several PWM periods, which gives the LED walkdown a fading trail. Sits between the LED register output and the board LED pins.

---
 rtl/led_pwm_fader_if.sv | 21 ++
 rtl/led_pwm_fader.sv | 87 ++++++++
 tb/tb_led_pwm_fader.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_pwm_fader_if.sv
// led_pwm_fader_if: LED register, duty load and fade control in; PWM drive and duty readback out.
// Latency: none; plain wires bundling the fader's bus-side signals.
// Backpressure: none; master drives controls every clock, slave returns registered outputs.
interface led_pwm_fader_if;
  logic [15:0] led_in;
  logic [7:0]  duty_d;
  logic        duty_ld;
  logic        fade_en;
  logic [15:0] led_out;
  logic [7:0]  duty;

  modport master (
    output led_in, duty_d, duty_ld, fade_en,
    input  led_out, duty
  );

  modport slave (
    input  led_in, duty_d, duty_ld, fade_en,
    output led_out, duty
  );
endinterface

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: PWM-dims 16 LED register bits with a global duty; released bits fade out linearly.
// Latency: led_in -> level 1 clock, level -> led_out 1 further clock (2 total, PWM phase permitting).
// Backpressure: none; free-running, inputs sampled every clock, duty_ld is a single-cycle strobe.
module led_pwm_fader #(
  parameter int         PRESCALE  = 16,
  parameter logic [7:0] FADE_STEP = 8'h20
) (
  input  logic           clock,
  input  logic           reset,
  led_pwm_fader_if.slave bus
);

  // Prescaler width; PRESCALE=1 still needs a one-bit counter that simply stays at 0.
  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]    pwm_cnt_q, pwm_cnt_d;
  logic [7:0]    duty_reg_q, duty_reg_d;
  logic [7:0]    level_q [16];
  logic [7:0]    level_d [16];
  logic [15:0]   led_out_q, led_out_d;
  logic          tick;
  logic          boundary;

  // tick advances the PWM counter; boundary marks the last clock of a full PWM period.
  assign tick     = (pre_cnt_q == PRE_LAST);
  assign boundary = tick && (pwm_cnt_q == 8'hFF);

  // Shared timebase: prescaler wraps at PRESCALE-1, PWM counter wraps 255 -> 0 on tick.
  always_comb begin
    pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
    pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
  end

  // Duty register: loads on strobe, otherwise holds.
  always_comb begin
    duty_reg_d = duty_reg_q;
    if (bus.duty_ld) begin
      duty_reg_d = bus.duty_d;
    end
  end

  // Per-channel level: on-bits track duty, off-bits either clear or decay once per PWM period.
  // The compare uses the current level and counter so led_out trails level by one clock.
  always_comb begin
    led_out_d = '0;
    for (int i = 0; i < 16; i++) begin
      level_d[i] = level_q[i];
      if (bus.led_in[i]) begin
        level_d[i] = duty_reg_q;
      end else if (!bus.fade_en) begin
        level_d[i] = 8'h00;
      end else if (boundary) begin
        // Saturating decay: never wraps below zero.
        level_d[i] = (level_q[i] > FADE_STEP) ? (level_q[i] - FADE_STEP) : 8'h00;
      end
      // Level 255 is therefore on for 255 of 256 steps; that is the intended maximum.
      led_out_d[i] = (level_q[i] > pwm_cnt_q);
    end
  end

  // State registers with asynchronous clear; duty comes up at full brightness.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_cnt_q  <= '0;
      pwm_cnt_q  <= 8'h00;
      duty_reg_q <= 8'hFF;
      led_out_q  <= 16'h0000;
      for (int i = 0; i < 16; i++) begin
        level_q[i] <= 8'h00;
      end
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      duty_reg_q <= duty_reg_d;
      led_out_q  <= led_out_d;
      for (int i = 0; i < 16; i++) begin
        level_q[i] <= level_d[i];
      end
    end
  end

  assign bus.led_out = led_out_q;
  assign bus.duty    = duty_reg_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// tb_led_pwm_fader: directed bench for led_pwm_fader with PRESCALE=2 (512-clock PWM period).
// Latency: inputs driven and outputs sampled on the falling edge, half a clock from the active edge.
// Backpressure: none; every wait on the design is bounded by a cycle budget.
module tb_led_pwm_fader;

  localparam int PRE = 2;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   hi_cnt [16];

  led_pwm_fader_if bus_if ();

  led_pwm_fader #(
    .PRESCALE (PRE),
    .FADE_STEP(8'h20)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(negedge clock);
  endtask

  // Count led_out high clocks per bit over one full PWM period (512 clocks).
  task automatic count_window();
    for (int i = 0; i < 16; i++) hi_cnt[i] = 0;
    for (int n = 0; n < 512; n++) begin
      step();
      for (int i = 0; i < 16; i++) begin
        if (bus_if.led_out[i]) hi_cnt[i] = hi_cnt[i] + 1;
      end
    end
  endtask

  // Advance until the PWM counter reaches pv (and optionally the last prescale clock).
  task automatic wait_phase(input logic [7:0] pv, input bit need_last, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (dut.pwm_cnt_q == pv && (!need_last || dut.pre_cnt_q == 1'(PRE - 1))) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic load_duty(input logic [7:0] v);
    bus_if.duty_d  = v;
    bus_if.duty_ld = 1'b1;
    step();
    bus_if.duty_ld = 1'b0;
  endtask

  task automatic test_reset();
    int others;
    // Bring the design to a non-reset state first: duty 80, all bits lit.
    reset = 1'b1;
    bus_if.led_in = 16'h0000; bus_if.duty_d = 8'h00; bus_if.duty_ld = 1'b0; bus_if.fade_en = 1'b0;
    step(); step();
    reset = 1'b0;
    bus_if.led_in = 16'hFFFF;
    load_duty(8'h80);
    repeat (20) step();
    // Assert reset between edges and look before any clock edge.
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (bus_if.led_out !== 16'h0000) begin
      n_fail++; $display("FAIL reset_led_out: got %h expected 0000", bus_if.led_out);
    end
    n_checks++;
    if (bus_if.duty !== 8'hFF) begin
      n_fail++; $display("FAIL reset_duty: got %h expected FF", bus_if.duty);
    end
    n_checks++;
    if (dut.level_q[0] !== 8'h00 || dut.pwm_cnt_q !== 8'h00) begin
      n_fail++; $display("FAIL reset_level_pwm: got level %h pwm %h expected 00 00", dut.level_q[0], dut.pwm_cnt_q);
    end
    bus_if.led_in = 16'h0001;
    step();
    reset = 1'b0;
    step();
    n_checks++;
    if (dut.level_q[0] !== 8'hFF || dut.level_q[1] !== 8'h00) begin
      n_fail++; $display("FAIL release_level: got %h/%h expected FF/00", dut.level_q[0], dut.level_q[1]);
    end
    step(); step();
    count_window();
    others = 0;
    for (int i = 1; i < 16; i++) others += hi_cnt[i];
    n_checks++;
    if (hi_cnt[0] != 510 || others != 0) begin
      n_fail++; $display("FAIL full_duty_count: got bit0 %0d others %0d expected 510 0", hi_cnt[0], others);
    end
  endtask

  task automatic test_duty_load();
    load_duty(8'h40);
    n_checks++;
    if (bus_if.duty !== 8'h40 || dut.level_q[0] !== 8'hFF) begin
      n_fail++; $display("FAIL duty_load: got duty %h level %h expected 40 FF", bus_if.duty, dut.level_q[0]);
    end
    step();
    n_checks++;
    if (dut.level_q[0] !== 8'h40) begin
      n_fail++; $display("FAIL duty_track: got %h expected 40", dut.level_q[0]);
    end
    step();
    count_window();
    n_checks++;
    if (hi_cnt[0] != 128) begin
      n_fail++; $display("FAIL duty40_count: got %0d expected 128", hi_cnt[0]);
    end
  endtask

  task automatic test_fade();
    logic [7:0] exp_lv [8];
    logic [7:0] prev;
    bit         ok;
    int         n;
    exp_lv = '{8'hDF, 8'hBF, 8'h9F, 8'h7F, 8'h5F, 8'h3F, 8'h1F, 8'h00};
    load_duty(8'hFF);
    bus_if.led_in  = 16'h0001;
    bus_if.fade_en = 1'b1;
    step(); step();
    wait_phase(8'd10, 1'b0, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL fade_align: got timeout expected pwm 0a");
    end
    bus_if.led_in = 16'h0002;
    step();
    n_checks++;
    if (dut.level_q[1] !== 8'hFF || dut.level_q[0] !== 8'hFF) begin
      n_fail++; $display("FAIL fade_start: got %h/%h expected FF/FF", dut.level_q[1], dut.level_q[0]);
    end
    for (int k = 0; k < 8; k++) begin
      prev = dut.level_q[0];
      n = 0;
      while (dut.level_q[0] === prev && n < 600) begin
        step();
        n++;
      end
      n_checks++;
      if (dut.level_q[0] !== exp_lv[k]) begin
        n_fail++; $display("FAIL fade_step%0d: got %h expected %h", k, dut.level_q[0], exp_lv[k]);
      end
      if (k > 0) begin
        n_checks++;
        if (n != 512) begin
          n_fail++; $display("FAIL fade_spacing%0d: got %0d clocks expected 512", k, n);
        end
      end
    end
    repeat (600) step();
    n_checks++;
    if (dut.level_q[0] !== 8'h00 || dut.level_q[1] !== 8'hFF) begin
      n_fail++; $display("FAIL fade_floor: got %h/%h expected 00/FF", dut.level_q[0], dut.level_q[1]);
    end
  endtask

  task automatic test_no_fade_and_resume();
    int n;
    bus_if.fade_en = 1'b0;
    bus_if.led_in  = 16'h0001;
    step(); step();
    bus_if.led_in = 16'h0000;
    step();
    n_checks++;
    if (dut.level_q[0] !== 8'h00) begin
      n_fail++; $display("FAIL nofade_level: got %h expected 00", dut.level_q[0]);
    end
    step();
    n_checks++;
    if (bus_if.led_out[0] !== 1'b0) begin
      n_fail++; $display("FAIL nofade_out: got %b expected 0", bus_if.led_out[0]);
    end
    // Start a fade, let it take one decay step, then turn the bit back on.
    bus_if.fade_en = 1'b1;
    bus_if.led_in  = 16'h0001;
    step(); step();
    bus_if.led_in = 16'h0000;
    n = 0;
    while (dut.level_q[0] === 8'hFF && n < 600) begin
      step();
      n++;
    end
    n_checks++;
    if (dut.level_q[0] !== 8'hDF) begin
      n_fail++; $display("FAIL midfade_level: got %h expected DF", dut.level_q[0]);
    end
    bus_if.led_in = 16'h0001;
    step();
    n_checks++;
    if (dut.level_q[0] !== 8'hFF) begin
      n_fail++; $display("FAIL midfade_resume: got %h expected FF", dut.level_q[0]);
    end
  endtask

  task automatic test_duty_on_boundary();
    bit         ok;
    logic [7:0] acc;
    int         total;
    bus_if.led_in = 16'hFFFF;
    step(); step();
    wait_phase(8'hFF, 1'b1, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL bnd_align: got timeout expected boundary");
    end
    load_duty(8'h00);
    n_checks++;
    if (bus_if.duty !== 8'h00 || dut.level_q[7] !== 8'hFF || dut.pwm_cnt_q !== 8'h00) begin
      n_fail++; $display("FAIL bnd_same_cycle: got duty %h level %h pwm %h expected 00 FF 00",
                         bus_if.duty, dut.level_q[7], dut.pwm_cnt_q);
    end
    step();
    acc = 8'h00;
    for (int i = 0; i < 16; i++) acc |= dut.level_q[i];
    n_checks++;
    if (acc !== 8'h00) begin
      n_fail++; $display("FAIL bnd_levels_zero: got or %h expected 00", acc);
    end
    step();
    count_window();
    total = 0;
    for (int i = 0; i < 16; i++) total += hi_cnt[i];
    n_checks++;
    if (total != 0) begin
      n_fail++; $display("FAIL bnd_dark: got %0d high clocks expected 0", total);
    end
  endtask

  task automatic test_reset_mid_fade();
    bit ok;
    int n;
    int others;
    load_duty(8'hFF);
    bus_if.led_in  = 16'hFFFF;
    bus_if.fade_en = 1'b1;
    step(); step(); step();
    wait_phase(8'd10, 1'b0, ok);
    bus_if.led_in = 16'h0000;
    n = 0;
    while (dut.level_q[3] === 8'hFF && n < 600) begin
      step();
      n++;
    end
    // A duty change while fading must not raise the fading level.
    load_duty(8'h80);
    step(); step();
    n_checks++;
    if (dut.level_q[3] !== 8'hDF) begin
      n_fail++; $display("FAIL fade_vs_duty: got %h expected DF", dut.level_q[3]);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (bus_if.led_out !== 16'h0000 || dut.level_q[3] !== 8'h00 || dut.pwm_cnt_q !== 8'h00 || dut.pre_cnt_q !== 1'b0) begin
      n_fail++; $display("FAIL midfade_reset: got out %h level %h pwm %h pre %h expected 0000 00 00 0",
                         bus_if.led_out, dut.level_q[3], dut.pwm_cnt_q, dut.pre_cnt_q);
    end
    bus_if.led_in = 16'h0001;
    step();
    reset = 1'b0;
    step();
    n_checks++;
    if (bus_if.duty !== 8'hFF || dut.level_q[0] !== 8'hFF || dut.level_q[3] !== 8'h00) begin
      n_fail++; $display("FAIL post_reset: got duty %h l0 %h l3 %h expected FF FF 00",
                         bus_if.duty, dut.level_q[0], dut.level_q[3]);
    end
    step(); step();
    count_window();
    others = 0;
    for (int i = 1; i < 16; i++) others += hi_cnt[i];
    n_checks++;
    if (hi_cnt[0] != 510 || others != 0) begin
      n_fail++; $display("FAIL post_reset_count: got bit0 %0d others %0d expected 510 0", hi_cnt[0], others);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus_if.led_in  = 16'h0000;
    bus_if.duty_d  = 8'h00;
    bus_if.duty_ld = 1'b0;
    bus_if.fade_en = 1'b0;
    test_reset();
    test_duty_load();
    test_fade();
    test_no_fade_and_resume();
    test_duty_on_boundary();
    test_reset_mid_fade();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
